// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: stepped-frequency sweep sequencer for the NCO core.
// Drives phi_inc/clken, holds each step for a dwell, drains the core pipeline and strobes new-frequency samples.
module nco_sweep_ctrl #(
    parameter int apr  = 32,
    parameter int cntw = 16,
    parameter int dww  = 16,
    parameter int lat  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [apr-1:0]  cfg_start_inc,
    input  logic [apr-1:0]  cfg_step,
    input  logic [cntw-1:0] cfg_num_steps,
    input  logic [dww-1:0]  cfg_dwell,
    input  logic            cfg_repeat,
    input  logic            start,
    input  logic            abort,
    output logic [apr-1:0]  phi_inc_o,
    output logic            nco_clken,
    output logic            busy,
    output logic            done,
    output logic [cntw-1:0] step_idx,
    output logic            freq_strobe
);
    typedef enum logic [1:0] {IDLE, DWELL, DRAIN} state_t;
    localparam int drw = $clog2(lat + 1);

    state_t          state_q, state_d;
    logic [apr-1:0]  phi_q, phi_d, sinc_q, sinc_d, sstep_q, sstep_d;
    logic [cntw-1:0] idx_q, idx_d, nsteps_q, nsteps_d;
    logic [dww-1:0]  dwell_q, dwell_d, cnt_q, cnt_d, dwell_eff;
    logic [drw-1:0]  drain_q, drain_d;
    logic [lat-1:0]  dl_q, dl_d;
    logic            rep_q, rep_d, clken_q, clken_d, busy_q, busy_d, done_q, done_d, ld_q, ld_d;

    assign dwell_eff   = (cfg_dwell == '0) ? dww'(1) : cfg_dwell;
    assign phi_inc_o   = phi_q;
    assign step_idx    = idx_q;
    assign nco_clken   = clken_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign freq_strobe = dl_q[lat-1];

    always_comb begin
        state_d  = state_q;
        phi_d    = phi_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        sinc_d   = sinc_q;
        sstep_d  = sstep_q;
        nsteps_d = nsteps_q;
        dwell_d  = dwell_q;
        rep_d    = rep_q;
        clken_d  = clken_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ld_d     = 1'b0;
        // ld_q is the entry stage: a load is visible one edge later, then rides the line only on enabled cycles
        dl_d     = clken_q ? ((dl_q << 1) | lat'(ld_q)) : dl_q;
        if (abort) begin
            state_d = IDLE;
            clken_d = 1'b0;
            busy_d  = 1'b0;
            dl_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sinc_d   = cfg_start_inc;
                    sstep_d  = cfg_step;
                    nsteps_d = cfg_num_steps;
                    dwell_d  = dwell_eff;
                    rep_d    = cfg_repeat;
                    if (cfg_num_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        phi_d   = cfg_start_inc;
                        idx_d   = '0;
                        cnt_d   = dwell_eff;
                        clken_d = 1'b1;
                        busy_d  = 1'b1;
                        ld_d    = 1'b1;
                        state_d = DWELL;
                    end
                end
                DWELL: if (cnt_q != dww'(1)) begin
                    cnt_d = cnt_q - dww'(1);
                end else if (idx_q != nsteps_q - cntw'(1)) begin
                    phi_d = phi_q + sstep_q;
                    idx_d = idx_q + cntw'(1);
                    cnt_d = dwell_q;
                    ld_d  = 1'b1;
                end else if (rep_q) begin
                    phi_d = sinc_q;
                    idx_d = '0;
                    cnt_d = dwell_q;
                    ld_d  = 1'b1;
                end else begin
                    drain_d = drw'(lat);
                    state_d = DRAIN;
                end
                DRAIN: if (drain_q == drw'(1)) begin
                    clken_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - drw'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            phi_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
            sinc_q   <= '0;
            sstep_q  <= '0;
            nsteps_q <= '0;
            dwell_q  <= '0;
            rep_q    <= 1'b0;
            clken_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ld_q     <= 1'b0;
            dl_q     <= '0;
        end else begin
            state_q  <= state_d;
            phi_q    <= phi_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            sinc_q   <= sinc_d;
            sstep_q  <= sstep_d;
            nsteps_q <= nsteps_d;
            dwell_q  <= dwell_d;
            rep_q    <= rep_d;
            clken_q  <= clken_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ld_q     <= ld_d;
            dl_q     <= dl_d;
        end
    end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequencer for the NCO core. Drives the core's phase-increment input and clock enable so it produces a stepped-frequency sweep (a linear chirp or a hop table).
- Holds each frequency for a programmable dwell and optionally repeats the sweep.
- Keeps the core clocked long enough to flush its pipeline at the end of a sweep.
- Emits a strobe aligned to the first output sample at each new frequency, for downstream CIC/UDP packet framing.

Parameters:
apr, 32, phase-increment width; must equal the NCO core apr
cntw, 16, step-count and step-index width
dww, 16, dwell-counter width
lat, 10, NCO latency in enabled cycles from phi_inc change to output at the new frequency

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_start_inc  in  apr  phase increment of step 0
cfg_step  in  apr  signed (two's complement) increment added per step
cfg_num_steps  in  cntw  number of frequency steps per sweep
cfg_dwell  in  dww  cycles per step
cfg_repeat  in  1  1 = loop the sweep until abort
start  in  1  single-cycle request to begin a sweep
abort  in  1  stop immediately
phi_inc_o  out  apr  to NCO phi_inc_i
nco_clken  out  1  to NCO clken
busy  out  1  sweep or drain in progress
done  out  1  one-cycle pulse at normal completion
step_idx  out  cntw  index of the frequency currently on phi_inc_o
freq_strobe  out  1  one-cycle pulse when NCO output first reflects a new step

Behaviour:
- Reset values: all outputs 0, state IDLE, delay line cleared. Reset asserted mid-sweep has the same effect.
- Shadow registers capture every cfg_* input on an accepted start. cfg changes during a sweep have no effect.
- A cfg_dwell of 0 is treated as 1.
- States are IDLE, DWELL and DRAIN.
- IDLE, start=1, cfg_num_steps=0:
  - done pulses the next cycle.
  - busy stays 0 and nco_clken stays 0.
- IDLE, start=1, cfg_num_steps>0 (all of the following take effect on the next edge):
  - phi_inc_o <= cfg_start_inc, step_idx <= 0, dwell counter <= dwell.
  - nco_clken <= 1, busy <= 1.
  - A load pulse enters the strobe delay line.
  - State goes to DWELL.
- DWELL: the counter decrements each cycle, so each step holds phi_inc_o for exactly dwell cycles.
- DWELL, counter==1 and step_idx < num_steps-1:
  - phi_inc_o <= phi_inc_o + step, modulo 2^apr with wrap and no saturation.
  - step_idx increments, the counter reloads, and a load pulse is issued.
- DWELL, counter==1 on the last step:
  - With repeat=1: phi_inc_o <= start_inc, step_idx <= 0, counter reloads, load pulse issued, state stays DWELL with no gap cycle.
  - With repeat=0: state goes to DRAIN with the drain counter = lat; phi_inc_o and step_idx are held.
- DRAIN:
  - nco_clken stays 1 for lat cycles.
  - Then, on one edge: nco_clken <= 0, busy <= 0, done pulses for 1 cycle, state goes to IDLE.
  - phi_inc_o holds its last value.
- abort (any state) has priority over start and over step events. Next cycle:
  - State goes to IDLE; nco_clken, busy and the delay line clear.
  - done is not pulsed; phi_inc_o and step_idx hold.
- start while busy is ignored.
- start and abort asserted in the same IDLE cycle: abort wins and no sweep starts.
- Strobe delay line:
  - lat-bit shift register that advances only when nco_clken=1.
  - freq_strobe is the last stage, so it fires exactly lat enabled cycles after each phi_inc_o update.
  - The strobe for the final step fires during DRAIN, before done.
- Constraint when dwell < lat: strobes still emerge one per step, each lat cycles after its load. They are never merged or dropped.
- Latency, start to first freq_strobe: lat+1 cycles.
- Total busy duration for a non-repeating sweep: num_steps*dwell + lat cycles.

Test Plan:
- Basic sweep: start_inc=100, step=10, num_steps=3, dwell=4, repeat=0, start pulse.
  - phi_inc_o=100/110/120 for 4 cycles each; nco_clken=1 for 22 cycles.
  - freq_strobe at cycles 11, 15 and 19 after start.
  - done at cycle 23; busy is 0 from then on.
- Wrap and negative step: start_inc=0xFFFF_FFF0, step=0x20, num_steps=2.
  - Second value is 0x0000_0010.
  - Repeat the run with step=0xFFFF_FFF0 (-16) from 8: second value is 0xFFFF_FFF8.
- Repeat mode: num_steps=2, dwell=3, repeat=1.
  - phi_inc_o cycles A, A+s, A, A+s…; step_idx toggles 0/1 every 3 cycles; done is never asserted.
  - abort at an arbitrary cycle: busy=0 and nco_clken=0 the next cycle, no done, no further freq_strobe.
- Edge configs:
  - num_steps=0: done one cycle after start, busy is never 1.
  - dwell=0: behaves as dwell=1, phi_inc_o changes every cycle.
  - dwell=1, lat=10: every freq_strobe is present, one per step.
- Contention:
  - start during DWELL is ignored and phi_inc_o is unaffected.
  - start and abort in the same IDLE cycle: stays IDLE.
  - cfg_step changed mid-sweep: increments still use the captured step.
- Reset mid-DWELL: all outputs are 0 asynchronously. After release, a new start behaves identically to the basic sweep.
